// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS-subset decode stage.
//   - opcode / funct constants of the supported instructions
//   - ALU op, next-PC source and register write-data source encodings
//   - decode_t: the decoded bundle carried by the stage output register
//   - uses_rs / uses_rt: which source registers an opcode actually reads
package mips_pkg;

    localparam logic [5:0] OpcR    = 6'h00;
    localparam logic [5:0] OpcJ    = 6'h02;
    localparam logic [5:0] OpcJal  = 6'h03;
    localparam logic [5:0] OpcBeq  = 6'h04;
    localparam logic [5:0] OpcBne  = 6'h05;
    localparam logic [5:0] OpcAddi = 6'h08;
    localparam logic [5:0] OpcXori = 6'h0e;
    localparam logic [5:0] OpcLw   = 6'h23;
    localparam logic [5:0] OpcSw   = 6'h2b;

    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnSlt = 6'h2a;

    localparam logic [4:0] LinkReg = 5'd31;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluXor = 3'd2,
        AluSlt = 3'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        PcPlus4  = 2'd0,
        PcJump   = 2'd1,
        PcJr     = 2'd2,
        PcBranch = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        DinAlu  = 2'd0,
        DinMem  = 2'd1,
        DinLink = 2'd2
    } reg_din_e;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  reg_waddr;
        alu_op_e     op;
        pc_src_e     pc_src;
        reg_din_e    reg_din;
        logic        reg_we;
        logic        dm_we;
        logic        alu_b_src;
        logic        bne;
        logic [31:0] imm;
        logic [25:0] j_addr;
        logic        illegal;
    } decode_t;

    // Every format except the J-type jumps carries a live rs field.
    function automatic logic uses_rs(input logic [5:0] opcode);
        return !((opcode == OpcJ) || (opcode == OpcJal));
    endfunction

    // rt is a source only for R-type, stores and the compare-and-branch pair.
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OpcR) || (opcode == OpcSw) ||
               (opcode == OpcBeq) || (opcode == OpcBne);
    endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: purely combinational MIPS-subset instruction decoder.
// Ports:
//   instr_i  32-bit instruction word
//   dec_o    decoded bundle (register fields, control, immediate, jump target)
// Unlisted opcodes/functs raise illegal with all side-effecting controls
// (reg_we, dm_we, pc_src) left at their inert defaults.
module decode_comb
    import mips_pkg::*;
(
    input  logic [31:0] instr_i,
    output decode_t     dec_o
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr_i[31:26];
    assign funct  = instr_i[5:0];

    always_comb begin
        dec_o           = '0;
        dec_o.rs        = instr_i[25:21];
        dec_o.rt        = instr_i[20:16];
        dec_o.rd        = instr_i[15:11];
        dec_o.j_addr    = instr_i[25:0];
        dec_o.reg_waddr = instr_i[20:16];
        dec_o.imm       = {{16{instr_i[15]}}, instr_i[15:0]};
        dec_o.op        = AluAdd;
        dec_o.pc_src    = PcPlus4;
        dec_o.reg_din   = DinAlu;

        case (opcode)
            OpcLw: begin
                dec_o.reg_we    = 1'b1;
                dec_o.reg_din   = DinMem;
                dec_o.alu_b_src = 1'b1;
            end
            OpcSw: begin
                dec_o.dm_we     = 1'b1;
                dec_o.alu_b_src = 1'b1;
            end
            OpcJ: begin
                dec_o.pc_src = PcJump;
            end
            OpcJal: begin
                dec_o.pc_src    = PcJump;
                dec_o.reg_we    = 1'b1;
                dec_o.reg_din   = DinLink;
                dec_o.reg_waddr = LinkReg;
            end
            OpcBeq: begin
                dec_o.op     = AluSub;
                dec_o.pc_src = PcBranch;
            end
            OpcBne: begin
                dec_o.op     = AluSub;
                dec_o.pc_src = PcBranch;
                dec_o.bne    = 1'b1;
            end
            OpcXori: begin
                dec_o.op        = AluXor;
                dec_o.alu_b_src = 1'b1;
                dec_o.reg_we    = 1'b1;
                dec_o.imm       = {16'h0000, instr_i[15:0]};
            end
            OpcAddi: begin
                dec_o.alu_b_src = 1'b1;
                dec_o.reg_we    = 1'b1;
            end
            OpcR: begin
                dec_o.reg_waddr = instr_i[15:11];
                case (funct)
                    FnAdd: begin
                        dec_o.reg_we = 1'b1;
                    end
                    FnSub: begin
                        dec_o.op     = AluSub;
                        dec_o.reg_we = 1'b1;
                    end
                    FnSlt: begin
                        dec_o.op     = AluSlt;
                        dec_o.reg_we = 1'b1;
                    end
                    FnJr: begin
                        dec_o.pc_src = PcJr;
                    end
                    default: begin
                        dec_o.illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: one-deep registered decode stage with valid/ready handshake,
// load-use hazard bubble insertion and a saturating illegal-instruction count.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   inValid / inReady        upstream handshake (instr, pc)
//   outValid / outReady      downstream handshake for the decoded bundle
//   rs..illegal, pcOut       registered decoded bundle
//   errCount                 saturating count of accepted illegal instructions
// Parameters:
//   STALL_CYCLES  load-use bubble length (0..3, 0 disables hazard detection)
//   ERR_CNT_W     width of errCount
module decode_stage
    import mips_pkg::*;
#(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [31:0]          instr,
    input  logic [31:0]          pc,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [4:0]           rs,
    output logic [4:0]           rt,
    output logic [4:0]           rd,
    output logic [4:0]           regWAddr,
    output logic [2:0]           op,
    output logic [1:0]           pcSrcCtrl,
    output logic [1:0]           regDInCtrl,
    output logic                 regWe,
    output logic                 dmWe,
    output logic                 aluBSrcCtrl,
    output logic                 bneCtrl,
    output logic [31:0]          imm,
    output logic [25:0]          jAddr,
    output logic [31:0]          pcOut,
    output logic                 illegal,
    output logic [ERR_CNT_W-1:0] errCount
);

    localparam logic [1:0]           StallLoad = 2'(STALL_CYCLES);
    localparam logic [ERR_CNT_W-1:0] ErrMax    = '1;

    typedef enum logic {
        StRun,
        StStall
    } state_e;

    decode_t dec;

    decode_comb u_decode_comb (
        .instr_i (instr),
        .dec_o   (dec)
    );

    // Hazard tracking / FSM state
    state_e     state_q;
    logic [1:0] stall_cnt_q;
    logic       last_was_load_q;
    logic [4:0] last_load_rt_q;

    // Output register
    logic                 out_valid_q, out_valid_d;
    decode_t              bundle_q, bundle_d;
    logic [31:0]          pc_q, pc_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [5:0] opcode;
    logic       rs_hit;
    logic       rt_hit;
    logic       hazard;
    logic       stall_active;
    logic       in_ready;
    logic       xfer;

    assign opcode = instr[31:26];
    assign rs_hit = uses_rs(opcode) && (dec.rs == last_load_rt_q);
    assign rt_hit = uses_rt(opcode) && (dec.rt == last_load_rt_q);

    assign hazard = (STALL_CYCLES != 0) && inValid && last_was_load_q &&
                    (last_load_rt_q != 5'd0) && (rs_hit || rt_hit);

    // The RUN cycle that detects the hazard is itself the first bubble, so the
    // STALL state only blocks while more than one bubble remains; the final
    // count-down cycle already lets the waiting instruction through.
    assign stall_active = ((state_q == StRun) && hazard) ||
                          ((state_q == StStall) && (stall_cnt_q > 2'd1));

    assign in_ready = (!out_valid_q || outReady) && !stall_active;
    assign xfer     = inValid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StRun;
            stall_cnt_q     <= 2'd0;
            last_was_load_q <= 1'b0;
            last_load_rt_q  <= 5'd0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (hazard) begin
                        state_q     <= StStall;
                        stall_cnt_q <= StallLoad;
                    end
                end
                StStall: begin
                    stall_cnt_q <= stall_cnt_q - 2'd1;
                    if (stall_cnt_q <= 2'd1) begin
                        state_q         <= StRun;
                        last_was_load_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
            // A transfer on the exit edge records the new instruction, which
            // must win over the stall's clearing of lastWasLoad.
            if (xfer) begin
                last_was_load_q <= (opcode == OpcLw);
                last_load_rt_q  <= dec.rt;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        pc_d        = pc_q;
        err_cnt_d   = err_cnt_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
            pc_d        = pc;
            if (dec.illegal && (err_cnt_q != ErrMax)) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end else if (outReady) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            pc_q        <= 32'd0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            pc_q        <= pc_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign inReady     = in_ready;
    assign outValid    = out_valid_q;
    assign rs          = bundle_q.rs;
    assign rt          = bundle_q.rt;
    assign rd          = bundle_q.rd;
    assign regWAddr    = bundle_q.reg_waddr;
    assign op          = bundle_q.op;
    assign pcSrcCtrl   = bundle_q.pc_src;
    assign regDInCtrl  = bundle_q.reg_din;
    assign regWe       = bundle_q.reg_we;
    assign dmWe        = bundle_q.dm_we;
    assign aluBSrcCtrl = bundle_q.alu_b_src;
    assign bneCtrl     = bundle_q.bne;
    assign imm         = bundle_q.imm;
    assign jAddr       = bundle_q.j_addr;
    assign pcOut       = pc_q;
    assign illegal     = bundle_q.illegal;
    assign errCount    = err_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed + randomized bench for decode_stage with a
// behavioural reference model (instruction table + bubble count + one-entry
// output slot) checked every cycle.
module tb_decode_stage;

    localparam int unsigned STALL  = 2;
    localparam int unsigned ERR_W  = 8;
    localparam int          ErrMax = 255;

    logic             clk;
    logic             rst_n;
    logic             inValid;
    logic             inReady;
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic             outValid;
    logic             outReady;
    logic [4:0]       rs, rt, rd, regWAddr;
    logic [2:0]       op;
    logic [1:0]       pcSrcCtrl, regDInCtrl;
    logic             regWe, dmWe, aluBSrcCtrl, bneCtrl;
    logic [31:0]      imm;
    logic [25:0]      jAddr;
    logic [31:0]      pcOut;
    logic             illegal;
    logic [ERR_W-1:0] errCount;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit        m_valid;
    bit        m_loaded;
    bit [31:0] m_instr;
    bit [31:0] m_pc;
    int        m_err;
    bit        m_last_load;
    bit [4:0]  m_last_rt;
    int        m_bubbles;

    typedef struct {
        bit        illegal;
        bit        we;
        bit        dmwe;
        bit [1:0]  pcsrc;
        bit        op_c;
        bit [2:0]  op;
        bit        din_c;
        bit [1:0]  din;
        bit        alub_c;
        bit        alub;
        bit        bne_c;
        bit        bne;
        bit        imm_c;
        bit [31:0] imm;
        bit        wa_c;
        bit [4:0]  wa;
    } exp_t;

    decode_stage #(
        .STALL_CYCLES (STALL),
        .ERR_CNT_W    (ERR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inValid     (inValid),
        .inReady     (inReady),
        .instr       (instr),
        .pc          (pc),
        .outValid    (outValid),
        .outReady    (outReady),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .regWAddr    (regWAddr),
        .op          (op),
        .pcSrcCtrl   (pcSrcCtrl),
        .regDInCtrl  (regDInCtrl),
        .regWe       (regWe),
        .dmWe        (dmWe),
        .aluBSrcCtrl (aluBSrcCtrl),
        .bneCtrl     (bneCtrl),
        .imm         (imm),
        .jAddr       (jAddr),
        .pcOut       (pcOut),
        .illegal     (illegal),
        .errCount    (errCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // Expected decode straight from the instruction table; *_c marks fields
    // the instruction actually defines.
    function automatic exp_t ref_decode(input bit [31:0] ins);
        exp_t      e;
        bit [5:0]  opc;
        bit [5:0]  fn;
        bit [31:0] simm;
        bit [31:0] zimm;
        bit        legal;
        opc   = ins[31:26];
        fn    = ins[5:0];
        simm  = {{16{ins[15]}}, ins[15:0]};
        zimm  = {16'h0000, ins[15:0]};
        e     = '{default: '0};
        legal = 1'b1;
        e.wa_c = 1'b1;
        e.wa   = ins[20:16];
        case (opc)
            6'h23: begin
                e.we = 1; e.op_c = 1; e.op = 3'd0; e.din_c = 1; e.din = 2'd1;
                e.alub_c = 1; e.alub = 1; e.imm_c = 1; e.imm = simm;
            end
            6'h2b: begin
                e.dmwe = 1; e.op_c = 1; e.op = 3'd0; e.alub_c = 1; e.alub = 1;
                e.imm_c = 1; e.imm = simm;
            end
            6'h02: e.pcsrc = 2'd1;
            6'h03: begin
                e.pcsrc = 2'd1; e.we = 1; e.din_c = 1; e.din = 2'd2; e.wa = 5'd31;
            end
            6'h04, 6'h05: begin
                e.pcsrc = 2'd3; e.op_c = 1; e.op = 3'd1; e.alub_c = 1; e.alub = 0;
                e.bne_c = 1; e.bne = (opc == 6'h05); e.imm_c = 1; e.imm = simm;
            end
            6'h0e: begin
                e.we = 1; e.op_c = 1; e.op = 3'd2; e.din_c = 1; e.din = 2'd0;
                e.alub_c = 1; e.alub = 1; e.imm_c = 1; e.imm = zimm;
            end
            6'h08: begin
                e.we = 1; e.op_c = 1; e.op = 3'd0; e.din_c = 1; e.din = 2'd0;
                e.alub_c = 1; e.alub = 1; e.imm_c = 1; e.imm = simm;
            end
            6'h00: begin
                e.wa = ins[15:11];
                case (fn)
                    6'h20, 6'h22, 6'h2a: begin
                        e.we = 1; e.op_c = 1; e.din_c = 1; e.din = 2'd0;
                        e.alub_c = 1; e.alub = 0;
                        e.op = (fn == 6'h20) ? 3'd0 : ((fn == 6'h22) ? 3'd1 : 3'd3);
                    end
                    6'h08: e.pcsrc = 2'd2;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        e.illegal = !legal;
        if (!legal) e.wa_c = 1'b0;
        return e;
    endfunction

    function automatic bit [31:0] rand_instr();
        bit [5:0]  opcs [12];
        bit [5:0]  fns [5];
        bit [31:0] ins;
        opcs = '{6'h23, 6'h2b, 6'h02, 6'h03, 6'h04, 6'h05,
                 6'h0e, 6'h08, 6'h00, 6'h00, 6'h00, 6'h3f};
        fns  = '{6'h20, 6'h22, 6'h2a, 6'h08, 6'h15};
        ins = $urandom;
        ins[31:26] = opcs[$urandom_range(0, 11)];
        ins[25:21] = 5'($urandom_range(0, 3));
        ins[20:16] = 5'($urandom_range(0, 3));
        if (ins[31:26] == 6'h00) begin
            ins[15:11] = 5'($urandom_range(0, 31));
            ins[5:0]   = fns[$urandom_range(0, 4)];
        end
        return ins;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid     = 1'b0;
        m_loaded    = 1'b0;
        m_instr     = 32'd0;
        m_pc        = 32'd0;
        m_err       = 0;
        m_last_load = 1'b0;
        m_last_rt   = 5'd0;
        m_bubbles   = 0;
    endtask

    task automatic check_outputs();
        exp_t e;
        e = ref_decode(m_instr);
        check("outValid", 32'(outValid), 32'(m_valid));
        check("errCount", 32'(errCount), 32'(m_err));
        if (!m_loaded) begin
            check("rst_fields", 32'({rs, rt, rd, regWAddr, op, pcSrcCtrl, regDInCtrl,
                                     regWe, dmWe, aluBSrcCtrl, bneCtrl, illegal}), 32'd0);
            check("rst_imm", imm, 32'd0);
            check("rst_jAddr", 32'(jAddr), 32'd0);
            check("rst_pcOut", pcOut, 32'd0);
        end else begin
            check("illegal", 32'(illegal), 32'(e.illegal));
            check("regWe", 32'(regWe), 32'(e.we));
            check("dmWe", 32'(dmWe), 32'(e.dmwe));
            check("pcSrcCtrl", 32'(pcSrcCtrl), 32'(e.pcsrc));
            check("rs", 32'(rs), 32'(m_instr[25:21]));
            check("rt", 32'(rt), 32'(m_instr[20:16]));
            check("rd", 32'(rd), 32'(m_instr[15:11]));
            check("jAddr", 32'(jAddr), 32'(m_instr[25:0]));
            check("pcOut", pcOut, m_pc);
            if (e.op_c) check("op", 32'(op), 32'(e.op));
            if (e.din_c) check("regDInCtrl", 32'(regDInCtrl), 32'(e.din));
            if (e.alub_c) check("aluBSrcCtrl", 32'(aluBSrcCtrl), 32'(e.alub));
            if (e.bne_c) check("bneCtrl", 32'(bneCtrl), 32'(e.bne));
            if (e.imm_c) check("imm", imm, e.imm);
            if (e.wa_c) check("regWAddr", 32'(regWAddr), 32'(e.wa));
        end
    endtask

    // Called at posedge+1: drive one cycle of inputs, check inReady, advance
    // the model over the next edge and check the registered outputs.
    task automatic step(input bit v, input bit [31:0] ins, input bit [31:0] p,
                        input bit ordy, output bit rdy);
        bit       hz, blocked, exp_rdy, xfer, use_rs, use_rt;
        bit [5:0] opc;
        bit [4:0] irs, irt;
        exp_t     e;
        inValid  = v;
        instr    = ins;
        pc       = p;
        outReady = ordy;
        opc = ins[31:26];
        irs = ins[25:21];
        irt = ins[20:16];
        use_rs = !(opc == 6'h02 || opc == 6'h03);
        use_rt = (opc == 6'h00 || opc == 6'h2b || opc == 6'h04 || opc == 6'h05);
        hz = (m_bubbles == 0) && (STALL > 0) && v && m_last_load && (m_last_rt != 5'd0) &&
             ((use_rs && irs == m_last_rt) || (use_rt && irt == m_last_rt));
        blocked = (m_bubbles > 0) || hz;
        exp_rdy = (!m_valid || ordy) && !blocked;
        #1;
        rdy = inReady;
        check("inReady", 32'(inReady), 32'(exp_rdy));
        xfer = v && exp_rdy;
        @(posedge clk);
        if (m_bubbles > 0) begin
            m_bubbles--;
            if (m_bubbles == 0) m_last_load = 1'b0;
        end else if (hz) begin
            m_bubbles = int'(STALL) - 1;
            if (m_bubbles == 0) m_last_load = 1'b0;
        end
        if (xfer) begin
            e           = ref_decode(ins);
            m_last_load = (opc == 6'h23);
            m_last_rt   = irt;
            m_valid     = 1'b1;
            m_loaded    = 1'b1;
            m_instr     = ins;
            m_pc        = p;
            if (e.illegal && m_err < ErrMax) m_err++;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    initial begin
        bit        r;
        int        low;
        int        n;
        bit        acc;
        bit [31:0] add_i, lw_i, ins_x, ins_y;
        bit [31:0] imm_x;

        rst_n    = 1'b0;
        inValid  = 1'b0;
        instr    = 32'd0;
        pc       = 32'd0;
        outReady = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs();
        check("rst_inReady", 32'(inReady), 32'd1);
        rst_n = 1'b1;

        // First edge after reset accepts; ADD r3 = r1 + r2.
        add_i = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
        step(1, add_i, 32'h100, 1, r);
        check("first_accept", 32'(r), 32'd1);
        check("add_outValid", 32'(outValid), 32'd1);
        check("add_op", 32'(op), 32'd0);
        check("add_regWe", 32'(regWe), 32'd1);
        check("add_regWAddr", 32'(regWAddr), 32'd3);
        check("add_aluB", 32'(aluBSrcCtrl), 32'd0);

        // Load-use: LW r5 then ADD using r5 -> exactly STALL bubbles.
        lw_i  = {6'h23, 5'd0, 5'd5, 16'h0010};
        add_i = {6'h00, 5'd5, 5'd1, 5'd4, 5'd0, 6'h20};
        step(1, lw_i, 32'h104, 1, r);
        check("lw_accept", 32'(r), 32'd1);
        low = 0;
        n   = 0;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            step(1, add_i, 32'h108, 1, r);
            n++;
            if (r) acc = 1'b1;
            else low++;
        end
        check("stall_accepted", 32'(acc), 32'd1);
        check("stall_low_cycles", 32'(low), 32'(STALL));
        check("stall_emit_cycle", 32'(n), 32'd3);
        check("stall_add_pc", pcOut, 32'h108);

        // LW into r0 never stalls.
        lw_i  = {6'h23, 5'd0, 5'd0, 16'hfff0};
        add_i = {6'h00, 5'd0, 5'd2, 5'd6, 5'd0, 6'h20};
        step(1, lw_i, 32'h200, 1, r);
        check("r0_lw_valid", 32'(outValid), 32'd1);
        step(1, add_i, 32'h204, 1, r);
        check("r0_no_stall", 32'(r), 32'd1);
        check("r0_b2b_valid", 32'(outValid), 32'd1);
        check("r0_b2b_pc", pcOut, 32'h204);

        // Backpressure: bundle held stable while outReady is low.
        step(0, 32'd0, 32'd0, 1, r);
        ins_x = {6'h0e, 5'd1, 5'd2, 16'h8001};
        ins_y = {6'h08, 5'd3, 5'd1, 16'h7ffe};
        step(1, ins_x, 32'h300, 0, r);
        check("bp_load", 32'(r), 32'd1);
        imm_x = imm;
        check("bp_xori_zext", imm_x, 32'h0000_8001);
        for (int i = 0; i < 3; i++) begin
            step(1, ins_y, 32'h304, 0, r);
            check("bp_inReady_low", 32'(r), 32'd0);
            check("bp_pc_hold", pcOut, 32'h300);
            check("bp_imm_hold", imm, imm_x);
        end
        step(1, ins_y, 32'h304, 1, r);
        check("bp_release", 32'(r), 32'd1);
        check("bp_next_pc", pcOut, 32'h304);

        // Illegal opcode flood: counter saturates.
        for (int i = 0; i < 300; i++) begin
            step(1, {6'h3f, 26'($urandom)}, 32'(i * 4), 1, r);
        end
        check("sat_errCount", 32'(errCount), 32'd255);
        check("sat_illegal", 32'(illegal), 32'd1);
        check("sat_regWe", 32'(regWe), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 9) < 8), rand_instr(), $urandom & 32'hffff_fffc,
                 ($urandom_range(0, 9) < 7), r);
        end

        // Reset asserted in the middle of a stall.
        for (int i = 0; i < 4; i++) step(0, 32'd0, 32'd0, 1, r);
        lw_i  = {6'h23, 5'd0, 5'd7, 16'h0004};
        add_i = {6'h00, 5'd7, 5'd7, 5'd2, 5'd0, 6'h22};
        step(1, lw_i, 32'h400, 1, r);
        step(1, add_i, 32'h404, 1, r);
        check("mid_stall_entered", 32'(r), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("rst_mid_inReady", 32'(inReady), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, add_i, 32'h404, 1, r);
        check("post_rst_no_bubble", 32'(r), 32'd1);
        check("post_rst_valid", 32'(outValid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter STALL_CYCLES, default 1, load-use bubble length in cycles (0..3; 0 disables hazard detection).
REQ-002 Parameter ERR_CNT_W, default 8, width of the illegal-instruction counter.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port inValid  input  1  instr/pc valid. Port inReady  output  1  stage accepts this cycle.
REQ-006 Port instr  input  32  MIPS-subset instruction. Port pc  input  32  its address.
REQ-007 Port outValid  output  1  decoded bundle valid. Port outReady  input  1  consumer accepts bundle.
REQ-008 Ports rs, rt, rd, regWAddr (5 each), op (3), pcSrcCtrl (2), regDInCtrl (2), regWe, dmWe, aluBSrcCtrl, bneCtrl (1 each), imm (32), jAddr (26), pcOut (32), illegal (1)  output  registered decoded bundle.
REQ-009 Port errCount  output  ERR_CNT_W  saturating count of illegal instructions accepted.

Function
REQ-010 Decode SHALL cover LW 0x23, SW 0x2b, J 0x02, JAL 0x03, BEQ 0x04, BNE 0x05, XORI 0x0e, ADDI 0x08, and R-type 0x00 with funct ADD 0x20, SUB 0x22, SLT 0x2a, JR 0x08.
REQ-011 Encodings SHALL be: op 0 add, 1 sub, 2 xor, 3 slt; pcSrcCtrl 0 pc+4, 1 jump, 2 jr, 3 branch; regDInCtrl 0 ALU, 1 memory, 2 link (pc+8).
REQ-012 imm SHALL be sign-extended instr[15:0] for LW/SW/ADDI/BEQ/BNE and zero-extended for XORI.
REQ-013 regWAddr SHALL be rd for R-type, 31 for JAL, rt otherwise; regWe SHALL be 1 only for LW, JAL, XORI, ADDI, ADD, SUB, SLT.
REQ-014 An unlisted opcode or funct SHALL set illegal=1 with regWe=0, dmWe=0, pcSrcCtrl=0, and increment errCount, saturating at all-ones.
REQ-015 inReady SHALL equal (!outValid || outReady) && !stallActive.
REQ-016 A transfer (inValid && inReady) SHALL load the output register on that edge; latency is one cycle; pcOut carries pc.
REQ-017 While outValid && !outReady, every output field SHALL hold stable.
REQ-018 If outReady && outValid without a new transfer, outValid SHALL clear next cycle.
REQ-019 The stage SHALL record lastWasLoad and lastLoadRt for every transferred instruction.
REQ-020 Hazard: inValid, lastWasLoad, lastLoadRt != 0, and lastLoadRt equal to incoming rs (all but J/JAL) or rt (R-type, SW, BEQ, BNE).
REQ-021 FSM RUN/STALL: in RUN, a hazard with STALL_CYCLES>0 SHALL load a counter with STALL_CYCLES, enter STALL, and hold inReady=0.
REQ-022 In STALL the counter SHALL decrement each cycle; on reaching 0 it SHALL clear lastWasLoad and return to RUN; output handshake continues.
REQ-023 A hazard and a full, stalled output SHALL be independent; inReady requires both to clear.
REQ-024 If inValid drops during STALL, the stall SHALL complete regardless.

Reset
REQ-025 Reset SHALL force outValid=0, all bundle fields and errCount to 0, lastWasLoad=0, counter=0, state RUN, asynchronously and at any point, including mid-stall.
REQ-026 The first edge after rst_n deassertion SHALL accept input if inValid=1.

Structure
REQ-027 The opcode/funct constants and the op, pcSrcCtrl and regDInCtrl encodings SHALL live in a shared package (mips_pkg).
REQ-028 The combinational decode SHALL be a sub-module, decode_comb; the handshake, hazard FSM and counters SHALL be in decode_stage.

Verification
REQ-029 ADD {0x00,rs=1,rt=2,rd=3,0x20} with outReady=1 -> next cycle outValid=1, op=0, regWe=1, regWAddr=3, aluBSrcCtrl=0.
REQ-030 LW rt=5, then ADD rs=5, STALL_CYCLES=2 -> inReady low exactly 2 cycles, ADD emitted on the third cycle after LW.
REQ-031 LW rt=0, then ADD rs=0 -> no stall; back-to-back outValid.
REQ-032 outReady=0 for 3 cycles with a bundle held -> fields stable, inReady=0; outReady=1 -> next instruction loads the following cycle.
REQ-033 Opcode 0x3f x 300 with ERR_CNT_W=8 -> illegal=1, regWe=0, errCount saturates at 255.
REQ-034 rst_n low mid-STALL -> outValid=0, inReady=1 once released, no pending bubble.
